// File: rtl/hyper_controller.sv
// Hypervisor control block: owns the hypervisor-mode flag, the external mapper bytes
// and a small register window (scratch, trap code, ctrl, status) at $D640-$D67F.
//
// state    | meaning
// ST_USER  | normal CPU operation, register writes ignored, enter request honoured
// ST_HYPER | hypervisor mode, register window writable, exit request honoured
module hyper_controller #(
    parameter logic [7:0] MAP0_RST = 8'h00,
    parameter logic [7:0] MAP1_RST = 8'h00,
    parameter logic [7:0] MAP2_RST = 8'h00,
    parameter logic [7:0] MAP3_RST = 8'h30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hyper_cs,
    input  logic [7:0] hyper_addr,
    input  logic [7:0] hyper_io_data_i,
    output logic [7:0] hyper_io_data_o,
    input  logic       cpu_write,
    input  logic       ready,
    input  logic [7:0] cpu_data_i,
    output logic       hyper_mode,
    input  logic       hyper_enter,
    input  logic       hyper_exit,
    output logic       map_enable_ext,
    input  logic [1:0] mapper_reg_sel,
    output logic [7:0] mapper_reg
);

    typedef enum logic {
        ST_USER  = 1'b0,
        ST_HYPER = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic        map_ext, map_ext_nxt;
    logic [7:0]  mapper  [4];
    logic [7:0]  scratch [16];
    logic [7:0]  trap_code;
    logic [7:0]  ctrl;
    logic [5:0]  idx;
    logic        wr;
    logic        enter_ok;
    logic        unused_addr_bits;

    assign idx              = hyper_addr[5:0];
    assign unused_addr_bits = ^hyper_addr[7:6];
    assign wr               = hyper_cs & cpu_write & ready & (state == ST_HYPER);
    assign enter_ok         = ready & hyper_enter & (state == ST_USER);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_USER;
            map_ext <= 1'b0;
        end else begin
            state   <= state_nxt;
            map_ext <= map_ext_nxt;
        end
    end

    // Exit is evaluated after the ctrl write so an exit always clears the mapper enable.
    always_comb begin
        state_nxt   = state;
        map_ext_nxt = map_ext;
        if (ready) begin
            case (state)
                ST_USER: begin
                    if (hyper_enter) begin
                        state_nxt   = ST_HYPER;
                        map_ext_nxt = ~ctrl[0];
                    end
                end
                ST_HYPER: begin
                    if (wr && idx == 6'h3D) begin
                        map_ext_nxt = ~hyper_io_data_i[0];
                    end
                    if (hyper_exit) begin
                        state_nxt   = ST_USER;
                        map_ext_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt   = ST_USER;
                    map_ext_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mapper[0] <= MAP0_RST;
            mapper[1] <= MAP1_RST;
            mapper[2] <= MAP2_RST;
            mapper[3] <= MAP3_RST;
            for (int i = 0; i < 16; i++) begin
                scratch[i] <= 8'h00;
            end
            trap_code <= 8'h00;
            ctrl      <= 8'h00;
        end else begin
            if (enter_ok) begin
                trap_code <= cpu_data_i;
            end
            if (wr) begin
                if (idx[5:2] == 4'h0) begin
                    mapper[idx[1:0]] <= hyper_io_data_i;
                end else if (idx[5:4] == 2'b01) begin
                    scratch[idx[3:0]] <= hyper_io_data_i;
                end else if (idx == 6'h3D) begin
                    ctrl <= hyper_io_data_i;
                end
            end
        end
    end

    always_comb begin
        hyper_io_data_o = 8'h00;
        if (idx[5:2] == 4'h0) begin
            hyper_io_data_o = mapper[idx[1:0]];
        end else if (idx[5:4] == 2'b01) begin
            hyper_io_data_o = scratch[idx[3:0]];
        end else begin
            case (idx)
                6'h3C:   hyper_io_data_o = trap_code;
                6'h3D:   hyper_io_data_o = ctrl;
                6'h3E:   hyper_io_data_o = {6'b000000, map_ext, (state == ST_HYPER)};
                default: hyper_io_data_o = 8'h00;
            endcase
        end
    end

    assign hyper_mode     = (state == ST_HYPER);
    assign map_enable_ext = map_ext;
    assign mapper_reg     = mapper[mapper_reg_sel];

endmodule

// File: tb/tb_hyper_controller.sv
// Scoreboard bench for hyper_controller: stimulus pushes expected read-back values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hyper_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       hyper_cs;
    logic [7:0] hyper_addr;
    logic [7:0] hyper_io_data_i;
    logic [7:0] hyper_io_data_o;
    logic       cpu_write;
    logic       ready;
    logic [7:0] cpu_data_i;
    logic       hyper_mode;
    logic       hyper_enter;
    logic       hyper_exit;
    logic       map_enable_ext;
    logic [1:0] mapper_reg_sel;
    logic [7:0] mapper_reg;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [7:0] mapr;
        logic       mode;
        logic       ext;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    hyper_controller dut (
        .clk            (clk),
        .reset          (reset),
        .hyper_cs       (hyper_cs),
        .hyper_addr     (hyper_addr),
        .hyper_io_data_i(hyper_io_data_i),
        .hyper_io_data_o(hyper_io_data_o),
        .cpu_write      (cpu_write),
        .ready          (ready),
        .cpu_data_i     (cpu_data_i),
        .hyper_mode     (hyper_mode),
        .hyper_enter    (hyper_enter),
        .hyper_exit     (hyper_exit),
        .map_enable_ext (map_enable_ext),
        .mapper_reg_sel (mapper_reg_sel),
        .mapper_reg     (mapper_reg)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string field, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s.%s got %h expected %h", nm, field, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp(e.name, "data",  hyper_io_data_o, e.data);
            cmp(e.name, "mapr",  mapper_reg,      e.mapr);
            cmp(e.name, "mode",  {7'b0, hyper_mode},     {7'b0, e.mode});
            cmp(e.name, "ext",   {7'b0, map_enable_ext}, {7'b0, e.ext});
        end
    end

    // One bus cycle; called and returns at posedge+1.
    task automatic step(input logic cs, input logic we, input logic rdy, input logic [7:0] addr,
                        input logic [7:0] din, input logic ent, input logic ext, input logic [7:0] cdat);
        hyper_cs        = cs;
        cpu_write       = we;
        ready           = rdy;
        hyper_addr      = addr;
        hyper_io_data_i = din;
        hyper_enter     = ent;
        hyper_exit      = ext;
        cpu_data_i      = cdat;
        @(posedge clk);
        #1;
        hyper_cs    = 1'b0;
        cpu_write   = 1'b0;
        ready       = 1'b1;
        hyper_enter = 1'b0;
        hyper_exit  = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [7:0] din);
        step(1'b1, 1'b1, 1'b1, addr, din, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic check(input string nm, input logic [7:0] addr, input logic [1:0] sel,
                         input logic [7:0] d, input logic [7:0] m, input logic mode, input logic ext);
        exp_t e;
        hyper_addr     = addr;
        mapper_reg_sel = sel;
        e.name = nm; e.data = d; e.mapr = m; e.mode = mode; e.ext = ext;
        q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            if (q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL %s monitor timeout, queue size %0d expected 0", nm, q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        hyper_cs = 1'b0; cpu_write = 1'b0; ready = 1'b1;
        hyper_addr = 8'h00; hyper_io_data_i = 8'h00; cpu_data_i = 8'h00;
        hyper_enter = 1'b0; hyper_exit = 1'b0; mapper_reg_sel = 2'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        check("rst_map0",   8'h00, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("rst_map1",   8'h01, 2'd1, 8'h00, 8'h00, 1'b0, 1'b0);
        check("rst_map2",   8'h02, 2'd2, 8'h00, 8'h00, 1'b0, 1'b0);
        check("rst_map3",   8'h03, 2'd3, 8'h30, 8'h30, 1'b0, 1'b0);
        check("rst_status", 8'h3E, 2'd3, 8'h00, 8'h30, 1'b0, 1'b0);

        wr_reg(8'h10, 8'h55);
        check("user_wr_ign", 8'h10, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00);
        check("user_exit_ign", 8'h3E, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);

        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h07);
        check("enter_trap",   8'h3C, 2'd0, 8'h07, 8'h00, 1'b1, 1'b1);
        check("enter_status", 8'hFE, 2'd3, 8'h03, 8'h30, 1'b1, 1'b1);

        wr_reg(8'h02, 8'hA5);
        wr_reg(8'h1F, 8'h5A);
        check("wr_scratch", 8'h1F, 2'd2, 8'h5A, 8'hA5, 1'b1, 1'b1);
        check("unmapped",   8'h20, 2'd2, 8'h00, 8'hA5, 1'b1, 1'b1);
        wr_reg(8'h3D, 8'h01);
        check("ctrl_inhib", 8'h3D, 2'd2, 8'h01, 8'hA5, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h99);
        check("reenter_ign", 8'h3C, 2'd2, 8'h07, 8'hA5, 1'b1, 1'b0);

        step(1'b1, 1'b1, 1'b0, 8'h02, 8'h77, 1'b0, 1'b0, 8'h00);
        check("ready0_frz", 8'h02, 2'd2, 8'hA5, 8'hA5, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00);
        check("ready0_exit", 8'h3E, 2'd2, 8'h01, 8'hA5, 1'b1, 1'b0);

        // Write and exit on the same edge: write lands, mode clears.
        step(1'b1, 1'b1, 1'b1, 8'h11, 8'h3C, 1'b0, 1'b1, 8'h00);
        check("exit_map2",  8'h02, 2'd2, 8'hA5, 8'hA5, 1'b0, 1'b0);
        check("exit_wr",    8'h11, 2'd3, 8'h3C, 8'h30, 1'b0, 1'b0);
        check("exit_ctrl",  8'h3D, 2'd2, 8'h01, 8'hA5, 1'b0, 1'b0);

        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h42);
        check("both_enter", 8'h3C, 2'd2, 8'h42, 8'hA5, 1'b1, 1'b0);
        wr_reg(8'h3D, 8'h80);
        check("ctrl_clear", 8'h3E, 2'd0, 8'h03, 8'h00, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h13);
        check("both_exit",  8'h3C, 2'd2, 8'h42, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h24);
        check("reenter_ext", 8'h3E, 2'd2, 8'h03, 8'hA5, 1'b1, 1'b1);

        #2;
        reset = 1'b1;
        check("async_rst_m2", 8'h3E, 2'd2, 8'h00, 8'h00, 1'b0, 1'b0);
        check("async_rst_m3", 8'h1F, 2'd3, 8'h00, 8'h30, 1'b0, 1'b0);
        reset = 1'b0;
        check("post_rst_ctrl", 8'h3D, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hyper_controller.md
Name: hyper_controller

Overview:
Hypervisor control block for the 4510-class CPU subsystem. It owns the hypervisor-mode flag and a small I/O register window, decoded externally at CPU addresses $D640–$D67F (hyper_cs). It also holds four mapper bytes that the CPU uses in place of its own MAP state while the external mapper is enabled. It sits beside the CPU, on the registered CPU address/data/write outputs.

Parameters:
MAP0_RST, 8'h00, reset value of mapper byte 0 (MAPLO low)
MAP1_RST, 8'h00, reset value of mapper byte 1 (MAPLO high)
MAP2_RST, 8'h00, reset value of mapper byte 2 (MAPHI low)
MAP3_RST, 8'h30, reset value of mapper byte 3 (MAPHI high)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
hyper_cs  input  1  register window selected ($D640–$D67F)
hyper_addr  input  8  CPU address[7:0]; register index = hyper_addr[5:0]
hyper_io_data_i  input  8  CPU write data (registered data_o)
hyper_io_data_o  output  8  read data for the addressed register
cpu_write  input  1  CPU write strobe (registered)
ready  input  1  bus ready; qualifies all state updates
cpu_data_i  input  8  CPU data-in bus; captured as trap code on entry
hyper_mode  output  1  1 while in hypervisor mode
hyper_enter  input  1  one-cycle CPU request to enter hypervisor
hyper_exit  input  1  one-cycle CPU request to leave hypervisor
map_enable_ext  output  1  1 = CPU uses mapper_reg instead of internal MAP
mapper_reg_sel  input  2  selects mapper byte 0–3
mapper_reg  output  8  selected mapper byte

Behaviour:
- Reset (async):
  - hyper_mode=0, map_enable_ext=0.
  - Mapper bytes take the MAPn_RST values.
  - Scratch bytes, trap code and ctrl = 0x00.
- Write strobe wr = hyper_cs & cpu_write & ready & hyper_mode. Writes outside hypervisor mode are ignored.
- Register map (index = hyper_addr[5:0]):
  - 0x00–0x03: mapper bytes 0–3, R/W.
  - 0x10–0x1F: 16 scratch bytes, R/W, used by hypervisor software to save CPU state.
  - 0x3C: trap code, read-only.
  - 0x3D: ctrl, R/W; bit0 = ext-mapper inhibit; other bits read back as written.
  - 0x3E: status, read-only; bit0 = hyper_mode, bit1 = map_enable_ext, bits7:2 = 0.
  - All other indices read 0x00; writes to them are ignored.
- hyper_io_data_o: combinational read of the addressed register, independent of hyper_cs and cpu_write.
- mapper_reg: combinational, = mapper byte[mapper_reg_sel].
- Entry: on a rising edge with hyper_enter & ready & !hyper_mode:
  - hyper_mode <= 1.
  - trap code <= cpu_data_i.
  - map_enable_ext <= !ctrl[0].
- hyper_enter while already in hyper_mode is ignored; trap code is not overwritten.
- Exit: on a rising edge with hyper_exit & ready & hyper_mode:
  - hyper_mode <= 0, map_enable_ext <= 0.
  - Scratch, mapper and ctrl registers are retained.
- hyper_exit outside hyper_mode is ignored.
- hyper_enter and hyper_exit asserted together: enter takes priority if not in hyper_mode, otherwise exit.
- A write to ctrl in hyper_mode updates map_enable_ext on the same edge: map_enable_ext <= !new ctrl[0].
- A register write in the same cycle as exit: the write completes, then mode clears.
- ready=0 freezes all state; outputs stay combinationally valid.
- Reset asserted mid-operation returns to reset state immediately, regardless of clk.
- Latency:
  - Register writes are visible on hyper_io_data_o and mapper_reg the cycle after the write edge.
  - hyper_mode and map_enable_ext change one edge after the request.

Test Plan:
- Reset, then read indices 0x00–0x03, 0x3E with mapper_reg_sel 0–3 -> reads 00,00,00,30,00; mapper_reg=00,00,00,30; hyper_mode=0; map_enable_ext=0.
- Not in hyper mode: write 0x55 to index 0x10 with cs/write/ready high -> index 0x10 still reads 0x00.
- Pulse hyper_enter with cpu_data_i=0x07 -> next cycle hyper_mode=1, map_enable_ext=1, index 0x3C reads 0x07, 0x3E reads 0x03.
- In hyper mode, write 0xA5 to index 0x02 and 0x5A to 0x1F -> mapper_reg(sel=2)=0xA5, index 0x1F reads 0x5A. Write 0x01 to 0x3D -> map_enable_ext=0. Pulse hyper_enter again with cpu_data_i=0x99 -> trap code stays 0x07.
- Write with ready=0 -> no change. Pulse hyper_exit -> hyper_mode=0, map_enable_ext=0, index 0x02 still 0xA5.
- Async reset asserted mid-cycle while in hyper mode -> hyper_mode=0 immediately, mapper bytes back to 00,00,00,30.
